// File: rtl/idli_sqi_rsp_m.sv
// SQI (quad-SPI) serial SRAM responder backed by an internal byte array.
// Optional RDMR/WRMR mode-register commands are enabled by IDLI_SQI_RSP_MODE_REG_EN.
module idli_sqi_rsp_m #(
    parameter int ADDR_W = 12
) (
    input  logic       i_sqr_gck,
    input  logic       i_sqr_rst,
    input  logic       i_sqr_sck,
    input  logic       i_sqr_cs,
    input  logic [3:0] i_sqr_sio,
    output logic [3:0] o_sqr_sio,
    output logic       o_sqr_oe,
    output logic       o_sqr_err
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE} state_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
`ifdef IDLI_SQI_RSP_MODE_REG_EN
    localparam logic [7:0] CMD_RDMR  = 8'h05;
    localparam logic [7:0] CMD_WRMR  = 8'h01;
`endif

    state_t            state, state_nxt;
    logic              sck_q;
    logic              rise, fall;
    logic              err_nxt;
    logic [3:0]        cmd_hi;
    logic [7:0]        cmd;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_shf;
    logic [ADDR_W-1:0] addr_nxt;
    logic [7:0]        data;
    logic [3:0]        wbuf;
    logic              hi;
    logic              is_rd;
    logic              is_mr;
    logic              we;
    logic [7:0]        mem [0:(1<<ADDR_W)-1];

`ifdef IDLI_SQI_RSP_MODE_REG_EN
    logic [1:0]        mode;
`else
    localparam logic [1:0] mode = 2'b01;
`endif

    // 00 holds the address, 10 wraps inside a 32-byte page, 01/11 are linear.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a, input logic [1:0] m);
        case (m)
            2'b00:   addr_inc = a;
            2'b10:   addr_inc = {a[ADDR_W-1:5], a[4:0] + 5'd1};
            default: addr_inc = a + ADDR_W'(1);
        endcase
    endfunction

    assign rise     = i_sqr_sck & ~sck_q;
    assign fall     = ~i_sqr_sck & sck_q;
    assign cmd      = {cmd_hi, i_sqr_sio};
    assign addr_shf = {addr[ADDR_W-5:0], i_sqr_sio};
    assign addr_nxt = addr_inc(addr, mode);
    assign we       = ~i_sqr_cs & rise & (state == WDATA) & ~hi & ~is_mr;

    always_ff @(posedge i_sqr_gck or posedge i_sqr_rst) begin
        if (i_sqr_rst) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        if (i_sqr_cs) begin
            state_nxt = IDLE;
        end else if (rise) begin
            case (state)
                IDLE: state_nxt = CMD;
                CMD: begin
                    case (cmd)
                        CMD_READ, CMD_WRITE: state_nxt = ADDR;
`ifdef IDLI_SQI_RSP_MODE_REG_EN
                        CMD_RDMR:            state_nxt = RDATA;
                        CMD_WRMR:            state_nxt = WDATA;
`endif
                        default: begin
                            state_nxt = IGNORE;
                            err_nxt   = 1'b1;
                        end
                    endcase
                end
                ADDR:    if (cnt == 3'd5) state_nxt = is_rd ? DUMMY : WDATA;
                DUMMY:   if (cnt == 3'd1) state_nxt = RDATA;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_sqr_gck or posedge i_sqr_rst) begin
        if (i_sqr_rst) begin
            sck_q     <= 1'b0;
            cmd_hi    <= 4'h0;
            cnt       <= 3'd0;
            addr      <= '0;
            data      <= 8'h00;
            wbuf      <= 4'h0;
            hi        <= 1'b1;
            is_rd     <= 1'b0;
            is_mr     <= 1'b0;
            o_sqr_sio <= 4'h0;
            o_sqr_oe  <= 1'b0;
            o_sqr_err <= 1'b0;
`ifdef IDLI_SQI_RSP_MODE_REG_EN
            mode      <= 2'b01;
`endif
        end else begin
            sck_q     <= i_sqr_sck;
            o_sqr_err <= err_nxt;
            if (i_sqr_cs) begin
                cnt       <= 3'd0;
                hi        <= 1'b1;
                o_sqr_oe  <= 1'b0;
                o_sqr_sio <= 4'h0;
            end else begin
                case (state)
                    IDLE: if (rise) cmd_hi <= i_sqr_sio;
                    CMD: if (rise) begin
                        cnt   <= 3'd0;
                        hi    <= 1'b1;
                        is_rd <= (cmd == CMD_READ);
                        is_mr <= 1'b0;
`ifdef IDLI_SQI_RSP_MODE_REG_EN
                        if (cmd == CMD_RDMR || cmd == CMD_WRMR) is_mr <= 1'b1;
                        if (cmd == CMD_RDMR) data <= {mode, 6'b0};
`endif
                    end
                    ADDR: if (rise) begin
                        addr <= addr_shf;
                        if (cnt == 3'd5) begin
                            cnt <= 3'd0;
                            if (is_rd) data <= mem[addr_shf];
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    DUMMY: if (rise) cnt <= cnt + 3'd1;
                    RDATA: if (fall) begin
                        o_sqr_oe <= 1'b1;
                        if (hi) begin
                            o_sqr_sio <= data[7:4];
                            hi        <= 1'b0;
                        end else begin
                            o_sqr_sio <= data[3:0];
                            hi        <= 1'b1;
                            if (is_mr) begin
                                data <= {mode, 6'b0};
                            end else begin
                                addr <= addr_nxt;
                                data <= mem[addr_nxt];
                            end
                        end
                    end
                    WDATA: if (rise) begin
                        if (hi) begin
                            wbuf <= i_sqr_sio;
                            hi   <= 1'b0;
                        end else begin
                            hi <= 1'b1;
`ifdef IDLI_SQI_RSP_MODE_REG_EN
                            if (is_mr) mode <= wbuf[3:2];
`endif
                            if (!is_mr) addr <= addr_nxt;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Array has no reset; a byte lands only when its low nibble is clocked in.
    always_ff @(posedge i_sqr_gck) begin
        if (we) mem[addr] <= {wbuf, i_sqr_sio};
    end

endmodule

// File: tb/tb_idli_sqi_rsp_m.sv
// Directed bench for idli_sqi_rsp_m: vector table of SQI transactions plus corner sequences.
module tb_idli_sqi_rsp_m;

    logic       gck, rst, sck, cs;
    logic [3:0] sio;
    logic [3:0] o_sqr_sio;
    logic       o_sqr_oe, o_sqr_err;

    int n_chk  = 0;
    int n_fail = 0;
    int err_cnt = 0;
    int oe_cnt  = 0;
    logic nib_oe;

    idli_sqi_rsp_m #(.ADDR_W(12)) dut (
        .i_sqr_gck(gck), .i_sqr_rst(rst), .i_sqr_sck(sck), .i_sqr_cs(cs),
        .i_sqr_sio(sio), .o_sqr_sio(o_sqr_sio), .o_sqr_oe(o_sqr_oe), .o_sqr_err(o_sqr_err)
    );

    initial gck = 1'b0;
    always #5 gck = ~gck;

    always @(negedge gck) begin
        if (o_sqr_err) err_cnt++;
        if (o_sqr_oe)  oe_cnt++;
    end

    typedef struct {
        logic        wr;
        logic [23:0] addr;
        int          n;
        logic [7:0]  d0;
        logic [7:0]  d1;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called on a negedge; sck low two cycles, high two cycles, sample before the fall.
    task automatic clk_nib(input logic [3:0] n, output logic [3:0] r);
        sio = n;
        repeat (2) @(negedge gck);
        sck = 1'b1;
        repeat (2) @(negedge gck);
        r = o_sqr_sio;
        nib_oe = o_sqr_oe;
        sck = 1'b0;
    endtask

    task automatic start(input logic [7:0] c, input logic [23:0] a, input logic rd);
        logic [3:0] r;
        @(negedge gck);
        cs = 1'b0;
        clk_nib(c[7:4], r);
        clk_nib(c[3:0], r);
        for (int i = 5; i >= 0; i--) clk_nib(a[i*4 +: 4], r);
        if (rd) begin
            clk_nib(4'h0, r); check("dummy_oe0", nib_oe, 0);
            clk_nib(4'h0, r); check("dummy_oe1", nib_oe, 0);
        end
    endtask

    task automatic wr_byte(input logic [7:0] d);
        logic [3:0] r;
        clk_nib(d[7:4], r);
        clk_nib(d[3:0], r);
    endtask

    task automatic rd_byte(output logic [7:0] q);
        logic [3:0] h, l;
        clk_nib(4'h0, h); check("data_oe_hi", nib_oe, 1);
        clk_nib(4'h0, l); check("data_oe_lo", nib_oe, 1);
        q = {h, l};
    endtask

    task automatic stop();
        @(negedge gck);
        cs = 1'b1;
        repeat (2) @(negedge gck);
        check("oe_after_cs", o_sqr_oe, 0);
    endtask

    initial begin
        vec_t       tbl [8];
        logic [7:0] q;
        logic [3:0] r;
        int         e0, o0;

        tbl[0] = '{1'b1, 24'h000010, 2, 8'hA5, 8'h3C};
        tbl[1] = '{1'b0, 24'h000010, 2, 8'hA5, 8'h3C};
        tbl[2] = '{1'b1, 24'h000FFF, 2, 8'h11, 8'h22};
        tbl[3] = '{1'b0, 24'h000FFF, 2, 8'h11, 8'h22};
        tbl[4] = '{1'b0, 24'h000000, 1, 8'h22, 8'h00};
        tbl[5] = '{1'b1, 24'hABC123, 1, 8'h5A, 8'h00};
        tbl[6] = '{1'b0, 24'h000123, 1, 8'h5A, 8'h00};
        tbl[7] = '{1'b1, 24'h000040, 2, 8'h00, 8'h99};

        rst = 1'b1; cs = 1'b1; sck = 1'b0; sio = 4'h0;
        repeat (3) @(negedge gck);
        check("rst_sio", o_sqr_sio, 0);
        check("rst_oe", o_sqr_oe, 0);
        check("rst_err", o_sqr_err, 0);
        rst = 1'b0;
        repeat (2) @(negedge gck);

        e0 = err_cnt;
        for (int v = 0; v < 8; v++) begin
            start(tbl[v].wr ? 8'h02 : 8'h03, tbl[v].addr, !tbl[v].wr);
            for (int b = 0; b < tbl[v].n; b++) begin
                if (tbl[v].wr) wr_byte(b == 0 ? tbl[v].d0 : tbl[v].d1);
                else begin
                    rd_byte(q);
                    check($sformatf("vec%0d_byte%0d", v, b), q, b == 0 ? tbl[v].d0 : tbl[v].d1);
                end
            end
            stop();
        end
        check("no_err_table", err_cnt - e0, 0);

        // Partial write byte must not land.
        start(8'h02, 24'h000040, 1'b0);
        wr_byte(8'h77);
        clk_nib(4'hF, r);
        stop();
        start(8'h03, 24'h000040, 1'b1);
        rd_byte(q); check("partial_0x40", q, 8'h77);
        rd_byte(q); check("partial_0x41", q, 8'h99);
        stop();

        // Low-nibble rise coinciding with cs deassert is dropped.
        start(8'h02, 24'h000041, 1'b0);
        clk_nib(4'h5, r);
        sio = 4'h6;
        repeat (2) @(negedge gck);
        sck = 1'b1; cs = 1'b1;
        repeat (2) @(negedge gck);
        sck = 1'b0;
        repeat (2) @(negedge gck);
        start(8'h03, 24'h000041, 1'b1);
        rd_byte(q); check("cs_wins_0x41", q, 8'h99);
        stop();

        // Unrecognised command.
        e0 = err_cnt; o0 = oe_cnt;
        start(8'hFF, 24'h000010, 1'b1);
        wr_byte(8'h00);
        stop();
        check("bad_cmd_err_cycles", err_cnt - e0, 1);
        check("bad_cmd_oe", oe_cnt - o0, 0);
        start(8'h03, 24'h000FFF, 1'b1);
        rd_byte(q); check("read_after_err", q, 8'h11);
        stop();

        // Async reset in the middle of a read.
        start(8'h03, 24'h000010, 1'b1);
        clk_nib(4'h0, r);
        check("pre_rst_nib", r, 4'hA);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_oe", o_sqr_oe, 0);
        check("mid_rst_sio", o_sqr_sio, 0);
        cs = 1'b1;
        @(negedge gck);
        rst = 1'b0;
        repeat (2) @(negedge gck);
        start(8'h03, 24'h000010, 1'b1);
        rd_byte(q); check("post_rst_b0", q, 8'hA5);
        rd_byte(q); check("post_rst_b1", q, 8'h3C);
        stop();

`ifdef IDLI_SQI_RSP_MODE_REG_EN
        @(negedge gck); cs = 1'b0;
        clk_nib(4'h0, r); clk_nib(4'h1, r);
        wr_byte(8'h80);
        stop();
        @(negedge gck); cs = 1'b0;
        clk_nib(4'h0, r); clk_nib(4'h5, r);
        rd_byte(q); check("rdmr_0", q, 8'h80);
        rd_byte(q); check("rdmr_1", q, 8'h80);
        stop();
        start(8'h02, 24'h00003F, 1'b0);
        wr_byte(8'hAA); wr_byte(8'hBB);
        stop();
        start(8'h03, 24'h000020, 1'b1);
        rd_byte(q); check("page_0x20", q, 8'hBB);
        stop();
        start(8'h03, 24'h00003F, 1'b1);
        rd_byte(q); check("page_rd_0x3F", q, 8'hAA);
        rd_byte(q); check("page_rd_wrap", q, 8'hBB);
        stop();
`else
        e0 = err_cnt;
        start(8'h05, 24'h000000, 1'b0);
        stop();
        check("rdmr_unrecognised", err_cnt - e0, 1);
        start(8'h03, 24'h000010, 1'b1);
        rd_byte(q); check("seq_after_rdmr", q, 8'hA5);
        stop();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
